// File: rtl/debounce_multi.sv
// debounce_multi: N-channel push-button debouncer with edge-pulse outputs.
//
// Each raw button is synchronised to clk. Its debounced level changes only
// after the synchronised input has disagreed with the level for STABLE_CYCLES
// consecutive cycles. Every accepted change produces a registered one-cycle
// press or release pulse.
//
// Optional feature (compile-time macro LONG_PRESS_EN): a per-channel hold
// counter pulses long_press once per press, LONG_CYCLES cycles after the
// press pulse. With the macro undefined, long_press is tied to 0.
//
// Ports:
//   clk           in  1     rising-edge clock
//   rst_n         in  1     synchronous reset, active low
//   btn_in        in  N_CH  raw asynchronous button inputs
//   btn_level     out N_CH  debounced level, 1 = pressed
//   press_pulse   out N_CH  1-cycle pulse on an accepted 0->1 of btn_level
//   release_pulse out N_CH  1-cycle pulse on an accepted 1->0 of btn_level
//   long_press    out N_CH  1-cycle pulse after a hold of LONG_CYCLES

// One debounce channel.
module debounce_lane #(
  parameter int STABLE_CYCLES = 250000,
  parameter int SYNC_STAGES   = 2,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter int LONG_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic release_p,
  output logic long_press
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  // Raw value meaning "not pressed"; also the polarity flip after the chain.
  localparam logic IDLE_RAW = ACTIVE_LOW;

  if (STABLE_CYCLES < 1 || SYNC_STAGES < 2 || LONG_CYCLES < 1) begin : g_bad_params
    $error("debounce_lane: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   s;
  logic                   accept;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{IDLE_RAW}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  assign s = sync_q[SYNC_STAGES-1] ^ IDLE_RAW;
  // s can only disagree with level in one direction, so cnt is simply the
  // length of the current run of disagreement.
  assign accept = (s != level) && (cnt == CW'(STABLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level     <= 1'b0;
      cnt       <= '0;
      press     <= 1'b0;
      release_p <= 1'b0;
    end else begin
      press     <= accept & s;
      release_p <= accept & ~s;
      if (accept) level <= s;
      if (s == level || accept) cnt <= '0;
      else                      cnt <= cnt + CW'(1);
    end
  end

`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  logic [HW-1:0] hold;

  // hold counts cycles since the press became visible; saturation at
  // LONG_CYCLES keeps the pulse to exactly one per press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= level && (hold == HW'(LONG_CYCLES - 1));
      if (!level)                         hold <= '0;
      else if (hold != HW'(LONG_CYCLES))  hold <= hold + HW'(1);
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

module debounce_multi #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 250000,
  parameter int SYNC_STAGES   = 2,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter int LONG_CYCLES   = 5000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_press
);

  debounce_lane #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES),
    .ACTIVE_LOW    (ACTIVE_LOW),
    .LONG_CYCLES   (LONG_CYCLES)
  ) u_lane [N_CH-1:0] (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_in),
    .level      (btn_level),
    .press      (press_pulse),
    .release_p  (release_pulse),
    .long_press (long_press)
  );

endmodule

// File: tb/tb_debounce_multi.sv
module tb_debounce_multi;
  localparam int N  = 4;
  localparam int ST = 4;
  localparam int SY = 2;
  localparam int LG = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_a = '0;     // active-high instance
  logic [N-1:0] btn_b = 4'hF;   // active-low instance
  logic [N-1:0] lvl_a, pp_a, rp_a, lp_a;
  logic [N-1:0] lvl_b, pp_b, rp_b, lp_b;

  debounce_multi #(.N_CH(N), .STABLE_CYCLES(ST), .SYNC_STAGES(SY),
                   .ACTIVE_LOW(1'b0), .LONG_CYCLES(LG)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_a), .btn_level(lvl_a),
    .press_pulse(pp_a), .release_pulse(rp_a), .long_press(lp_a));

  debounce_multi #(.N_CH(N), .STABLE_CYCLES(ST), .SYNC_STAGES(SY),
                   .ACTIVE_LOW(1'b1), .LONG_CYCLES(LG)) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_b), .btn_level(lvl_b),
    .press_pulse(pp_b), .release_pulse(rp_b), .long_press(lp_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a channel's level flips when the last ST synchronised
  // samples (each = the pressed-domain input from SY edges earlier) all
  // disagree with the current level. Age = cycles since the press appeared.
  logic [N-1:0] m_raw [2][SY];
  logic [N-1:0] m_s   [2][ST];
  logic [N-1:0] m_lvl [2];
  logic [N-1:0] m_pp  [2];
  logic [N-1:0] m_rp  [2];
  logic [N-1:0] m_lp  [2];
  int           m_age [2][N];

  task automatic model_edge(input int m, input logic rst, input logic [N-1:0] raw);
    logic [N-1:0] pr, s_now, old, nw;
    bit all_diff;
    pr = (m == 1) ? ~raw : raw;
    if (!rst) begin
      for (int k = 0; k < SY; k++) m_raw[m][k] = '0;
      for (int k = 0; k < ST; k++) m_s[m][k] = '0;
      m_lvl[m] = '0; m_pp[m] = '0; m_rp[m] = '0; m_lp[m] = '0;
      for (int c = 0; c < N; c++) m_age[m][c] = 0;
      return;
    end
    s_now = m_raw[m][SY-1];
    for (int k = SY-1; k > 0; k--) m_raw[m][k] = m_raw[m][k-1];
    m_raw[m][0] = pr;
    for (int k = ST-1; k > 0; k--) m_s[m][k] = m_s[m][k-1];
    m_s[m][0] = s_now;
    old = m_lvl[m];
    nw  = old;
    for (int c = 0; c < N; c++) begin
      all_diff = 1'b1;
      for (int k = 0; k < ST; k++) if (m_s[m][k][c] == old[c]) all_diff = 1'b0;
      if (all_diff) nw[c] = ~old[c];
    end
    m_pp[m] = nw & ~old;
    m_rp[m] = ~nw & old;
    m_lp[m] = '0;
    for (int c = 0; c < N; c++) begin
`ifdef LONG_PRESS_EN
      m_lp[m][c] = old[c] && (m_age[m][c] == LG - 1);
`endif
      if (!nw[c] || !old[c]) m_age[m][c] = 0;
      else if (m_age[m][c] < LG) m_age[m][c]++;
    end
    m_lvl[m] = nw;
  endtask

  task automatic step(input logic [N-1:0] a, input logic [N-1:0] b);
    btn_a = a;
    btn_b = b;
    @(posedge clk);
    model_edge(0, rst_n, a);
    model_edge(1, rst_n, b);
    #1;
    chk("model_lvl_a", lvl_a, m_lvl[0]);
    chk("model_pp_a",  pp_a,  m_pp[0]);
    chk("model_rp_a",  rp_a,  m_rp[0]);
    chk("model_lp_a",  lp_a,  m_lp[0]);
    chk("model_lvl_b", lvl_b, m_lvl[1]);
    chk("model_pp_b",  pp_b,  m_pp[1]);
    chk("model_rp_b",  rp_b,  m_rp[1]);
    chk("model_lp_b",  lp_b,  m_lp[1]);
  endtask

  task automatic do_reset(input logic [N-1:0] a, input logic [N-1:0] b);
    rst_n = 1'b0;
    repeat (2) step(a, b);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic b;     // btn_a[0]
    logic lvl;   // expected btn_level[0]
    logic pp;    // expected press_pulse[0]
    logic rp;    // expected release_pulse[0]
  } vec_t;

  vec_t tbl[20];

  initial begin : main
    int pcyc, lcyc, nlong;
    logic [N-1:0] a, b, mask;
    int prob;

    // Clean press/release of ch0: input high at edges 1..9, low from edge 10.
    for (int i = 0; i < 20; i++) begin
      tbl[i].b   = (i < 9);
      tbl[i].lvl = (i >= 5 && i <= 13);
      tbl[i].pp  = (i == 5);
      tbl[i].rp  = (i == 14);
    end

    // 1. Reset with all buttons pressed.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(4'hF, 4'hF);
      chk("t1_rst_level", lvl_a, 0);
      chk("t1_rst_press", pp_a, 0);
      chk("t1_rst_release", rp_a, 0);
      chk("t1_rst_long", lp_a, 0);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step(4'hF, 4'hF);
      chk("t1_level", lvl_a, (i >= 6) ? 4'hF : 4'h0);
      chk("t1_press", pp_a, (i == 6) ? 4'hF : 4'h0);
      chk("t1_level_al_idle", lvl_b, 0);
    end

    // 2. Table-driven clean press/release on ch0.
    do_reset(4'h0, 4'hF);
    for (int i = 0; i < 20; i++) begin
      step({3'b000, tbl[i].b}, 4'hF);
      chk("t2_level0", lvl_a[0], tbl[i].lvl);
      chk("t2_press0", pp_a[0], tbl[i].pp);
      chk("t2_release0", rp_a[0], tbl[i].rp);
    end

    // 3. Bounce on ch1, then a steady hold.
    do_reset(4'h0, 4'hF);
    for (int c = 0; c < 20; c++) begin
      step({2'b00, ((c / 2) % 2) == 0, 1'b0}, 4'hF);
      chk("t3_bounce_press", pp_a[1], 0);
      chk("t3_bounce_level", lvl_a[1], 0);
    end
    for (int i = 1; i <= 8; i++) begin
      step(4'b0010, 4'hF);
      chk("t3_hold_press", pp_a[1], i == 6);
      chk("t3_hold_level", lvl_a[1], i >= 6);
    end

    // 4. 3-cycle glitch on ch2.
    do_reset(4'h0, 4'hF);
    for (int i = 0; i < 13; i++) begin
      step((i < 3) ? 4'b0100 : 4'b0000, 4'hF);
      chk("t4_glitch_level", lvl_a[2], 0);
      chk("t4_glitch_press", pp_a[2], 0);
      chk("t4_glitch_release", rp_a[2], 0);
    end

    // 5. Active-low simultaneous press on ch0 and ch3, then mid-debounce reset.
    do_reset(4'h0, 4'hF);
    repeat (3) step(4'h0, 4'hF);
    for (int i = 1; i <= 7; i++) begin
      step(4'h0, 4'h6);
      chk("t5_al_press", pp_b, (i == 6) ? 4'h9 : 4'h0);
      chk("t5_al_level", lvl_b, (i >= 6) ? 4'h9 : 4'h0);
    end
    do_reset(4'h0, 4'hF);
    repeat (4) step(4'h0, 4'h6);
    rst_n = 1'b0;
    step(4'h0, 4'h6);
    chk("t5_midrst_level", lvl_b, 0);
    chk("t5_midrst_press", pp_b, 0);
    chk("t5_midrst_release", rp_b, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(4'h0, 4'h6);
      chk("t5_after_rst_level", lvl_b, (i >= 6) ? 4'h9 : 4'h0);
      chk("t5_after_rst_press", pp_b, (i == 6) ? 4'h9 : 4'h0);
    end

    // 6. Long hold on ch0.
    do_reset(4'h0, 4'hF);
    pcyc = -1; lcyc = -1; nlong = 0;
    for (int i = 1; i <= 40; i++) begin
      step((i <= 30) ? 4'h1 : 4'h0, 4'hF);
      if (pp_a[0]) pcyc = i;
      if (lp_a[0]) begin lcyc = i; nlong++; end
    end
    chk("t6_press_seen", pcyc, 6);
`ifdef LONG_PRESS_EN
    chk("t6_long_count", nlong, 1);
    chk("t6_long_delay", lcyc - pcyc, LG);
`else
    chk("t6_long_count", nlong, 0);
`endif

    // 7. Randomised run against the model, with occasional resets.
    do_reset(4'h0, 4'hF);
    a = '0; b = 4'hF; prob = 5;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: prob = 3;
          1: prob = 8;
          default: prob = 40;
        endcase
      end
      for (int c = 0; c < N; c++) begin
        mask[c] = ($urandom_range(0, prob - 1) == 0);
      end
      a = a ^ mask;
      for (int c = 0; c < N; c++) begin
        mask[c] = ($urandom_range(0, prob - 1) == 0);
      end
      b = b ^ mask;
      rst_n = ($urandom_range(0, 399) != 0);
      step(a, b);
      chk("rnd_no_overlap_a", pp_a & rp_a, 0);
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
